trigger_event_reader: RTL

TRIGGER_EVENT_READER -- requirements
Module: trigger_event_reader

---
 rtl/trigger_event_reader.sv | 81 ++++++++
 1 files changed

// File: rtl/trigger_event_reader.sv
// trigger_event_reader: timestamps rising edges of TRIGGER_IN with a sequence number into a FWFT FIFO.
module trigger_event_reader #(
  parameter int DEPTH = 16,
  parameter int SEQ_W = 8
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     TRIGGER_IN,
  input  logic                     read_mode,
  input  logic                     CLEAR,
  output logic [31:0]              DOUT,
  output logic                     DOUT_VALID,
  input  logic                     DOUT_READY,
  output logic [$clog2(DEPTH):0]   FILL,
  output logic                     OVERFLOW,
  output logic [15:0]              DROP_COUNT
);
  localparam int AW = $clog2(DEPTH);
  localparam int TS_W = 32 - SEQ_W;
  logic [TS_W-1:0] ts;
  logic [SEQ_W-1:0] seq;
  logic trig_q;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [AW:0] fill_nxt;
  logic evt, pop, push, drop, full, store_ok;
  logic [31:0] entry, dout_nxt;
  always_comb begin
    evt = TRIGGER_IN & ~trig_q;
    full = FILL[AW];
    pop = DOUT_VALID & DOUT_READY;
    store_ok = evt & ~read_mode & ~CLEAR;
    push = store_ok & (~full | pop);
    drop = store_ok & full & ~pop;
    entry = {seq, ts};
    rd_nxt = rd_ptr + 1'b1;
    fill_nxt = FILL + (AW+1)'(push) - (AW+1)'(pop);
    // head register follows the next oldest entry, or the incoming one when it becomes the head
    dout_nxt = pop ? (|FILL[AW:1] ? mem[rd_nxt] : push ? entry : DOUT)
                   : (~|FILL && push) ? entry : DOUT;
  end
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= entry;
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ts <= '0;
      seq <= '0;
      trig_q <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      FILL <= '0;
      DOUT_VALID <= 1'b0;
      DOUT <= '0;
      OVERFLOW <= 1'b0;
      DROP_COUNT <= '0;
    end else begin
      ts <= ts + 1'b1;
      trig_q <= TRIGGER_IN;
      if (CLEAR) begin
        seq <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        FILL <= '0;
        DOUT_VALID <= 1'b0;
        DOUT <= '0;
        OVERFLOW <= 1'b0;
        DROP_COUNT <= '0;
      end else begin
        if (evt) seq <= seq + 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_nxt;
        FILL <= fill_nxt;
        DOUT_VALID <= |fill_nxt;
        DOUT <= dout_nxt;
        if (drop) OVERFLOW <= 1'b1;
        if (drop && DROP_COUNT != 16'hFFFF) DROP_COUNT <= DROP_COUNT + 1'b1;
      end
    end
  end
endmodule
